dmem_arbiter: RTL and testbench

- Two-requester arbiter sharing the single data-memory port (`data_mem` instance) between the core load/store path (port 0) and a program-loader/DMA engine (port 1).
- Round-robin arbitration, one memory access per grant cycle, registered command to memory, registered read return.
- Port 0 stalls the core (holds PC enable low) while its request is pending, so the otherwise single-cycle core tolerates contention.

---
 rtl/dmem_arbiter.sv | 137 +++++++++++++
 tb/tb_dmem_arbiter.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing the data-memory port between the core (port 0) and the loader/DMA (port 1).
// Optional ownership lock for atomic read-modify-write is enabled with DMEM_ARB_LOCK_EN.
module dmem_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MEMI_W   = 5,
    parameter int LOCK_MAX = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    input  logic [MEMI_W-1:0] memi0,
    input  logic [MEMI_W-1:0] memi1,
    input  logic              lock0,
    input  logic              lock1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata,
    output logic              stall0,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [MEMI_W-1:0] mem_memi,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [1:0]        arb_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY0 = 2'd1,
        BUSY1 = 2'd2
    } state_t;

    state_t state, state_nx;
    logic   last_winner;
    logic   win, win_valid;

`ifdef DMEM_ARB_LOCK_EN
    localparam int CNT_W = $clog2(LOCK_MAX + 1);
    logic [CNT_W-1:0] lock_cnt;
    logic             owner, owner_lock, force_switch, win_lock;

    assign owner        = (state == BUSY1);
    assign owner_lock   = ((state == BUSY0) && lock0) || ((state == BUSY1) && lock1);
    assign force_switch = req0 && req1 && owner_lock && (lock_cnt == CNT_W'(LOCK_MAX));
    assign win_lock     = win ? lock1 : lock0;

    // Counts consecutive locked grants to the same owner while the other port waits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_cnt <= '0;
        end else if (req0 && req1 && win_lock && !force_switch) begin
            if ((state != IDLE) && (win == owner)) begin
                if (lock_cnt != CNT_W'(LOCK_MAX))
                    lock_cnt <= lock_cnt + CNT_W'(1);
            end else begin
                lock_cnt <= CNT_W'(1);
            end
        end else begin
            lock_cnt <= '0;
        end
    end
`else
    logic unused_lock;
    assign unused_lock = lock0 ^ lock1;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        win       = 1'b0;
        win_valid = 1'b0;
        state_nx  = IDLE;
        if (req0 && req1) begin
            win_valid = 1'b1;
            win       = ~last_winner;
`ifdef DMEM_ARB_LOCK_EN
            if (owner_lock)
                win = force_switch ? ~owner : owner;
`endif
        end else if (req0) begin
            win_valid = 1'b1;
            win       = 1'b0;
        end else if (req1) begin
            win_valid = 1'b1;
            win       = 1'b1;
        end
        if (win_valid)
            state_nx = win ? BUSY1 : BUSY0;
    end

    // mem_we doubles as the latched access type of the command currently on the port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_winner <= 1'b1;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            mem_memi    <= '0;
            rdata       <= '0;
            rvalid0     <= 1'b0;
            rvalid1     <= 1'b0;
        end else begin
            rvalid0 <= (state == BUSY0) && !mem_we;
            rvalid1 <= (state == BUSY1) && !mem_we;
            if ((state != IDLE) && !mem_we)
                rdata <= mem_rdata;
            if (win_valid) begin
                last_winner <= win;
                mem_we      <= win ? we1    : we0;
                mem_addr    <= win ? addr1  : addr0;
                mem_wdata   <= win ? wdata1 : wdata0;
                mem_memi    <= win ? memi1  : memi0;
            end else begin
                mem_we <= 1'b0;
            end
        end
    end

    assign gnt0      = (state == BUSY0);
    assign gnt1      = (state == BUSY1);
    assign stall0    = req0 & ~gnt0;
    assign arb_state = state;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus randomized traffic against
// a behavioural model of grants, memory contents and read returns.
module tb_dmem_arbiter;
    localparam int ADDR_W   = 32;
    localparam int DATA_W   = 32;
    localparam int MEMI_W   = 5;
    localparam int LOCK_MAX = 4;
`ifdef DMEM_ARB_LOCK_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    logic              clk   = 1'b0;
    logic              rst_n = 1'b1;
    logic              req0, req1, we0, we1, lock0, lock1;
    logic [ADDR_W-1:0] addr0, addr1;
    logic [DATA_W-1:0] wdata0, wdata1;
    logic [MEMI_W-1:0] memi0, memi1;
    logic              gnt0, gnt1, rvalid0, rvalid1, stall0, mem_we;
    logic [DATA_W-1:0] rdata, mem_wdata, mem_rdata;
    logic [ADDR_W-1:0] mem_addr;
    logic [MEMI_W-1:0] mem_memi;
    logic [1:0]        state_unused;

    dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEMI_W(MEMI_W), .LOCK_MAX(LOCK_MAX)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .memi0(memi0), .memi1(memi1), .lock0(lock0), .lock1(lock1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata(rdata), .stall0(stall0), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_memi(mem_memi), .mem_rdata(mem_rdata),
        .arb_state(state_unused)
    );

    // Clock/reset block and the data memory seen by the arbiter.
    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(input int i);
        return (i == 4) ? 32'hDEADBEEF : (32'hC0DE0000 | 32'(i));
    endfunction

    logic [DATA_W-1:0] mem [0:63];
    bit                mem_loaded = 1'b0;
    assign mem_rdata = mem[mem_addr[7:2]];
    always @(posedge clk) begin
        if (!mem_loaded) begin
            for (int i = 0; i < 64; i++) mem[i] <= init_word(i);
            mem_loaded <= 1'b1;
        end else if (mem_we) begin
            mem[mem_addr[7:2]] <= mem_wdata;
        end
    end

    // Reference model and scoreboard.
    int                n_checks = 0;
    int                n_errors = 0;
    logic [DATA_W-1:0] ref_mem [0:63];
    logic [DATA_W-1:0] exp_q[$];
    int                g_cur, last_w, lock_n;
    logic              c_we;
    logic [ADDR_W-1:0] c_addr;
    logic [DATA_W-1:0] c_wdata;
    logic [MEMI_W-1:0] c_memi;
    logic              exp_rv0, exp_rv1;
    logic [DATA_W-1:0] exp_rdata;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic lock_of(input int p);
        return (p == 0) ? lock0 : lock1;
    endfunction

    task automatic model_reset();
        g_cur = -1; last_w = 1; lock_n = 0;
        c_we = 1'b0; exp_rv0 = 1'b0; exp_rv1 = 1'b0; exp_rdata = '0;
        exp_q.delete();
    endtask

    // Evaluated with the input values present at a rising edge.
    task automatic model_edge();
        int w;
        bit forced;
        exp_rv0 = 1'b0;
        exp_rv1 = 1'b0;
        if (g_cur >= 0) begin
            if (c_we) begin
                ref_mem[c_addr[7:2]] = c_wdata;
            end else begin
                exp_q.push_back(ref_mem[c_addr[7:2]]);
                if (g_cur == 0) exp_rv0 = 1'b1;
                else            exp_rv1 = 1'b1;
            end
        end
        w = -1;
        forced = 1'b0;
        if (req0 && req1) begin
            w = (last_w == 0) ? 1 : 0;
            if (LOCK_EN && g_cur >= 0 && lock_of(g_cur)) begin
                if (lock_n == LOCK_MAX) begin
                    w = 1 - g_cur;
                    forced = 1'b1;
                end else begin
                    w = g_cur;
                end
            end
        end else if (req0) begin
            w = 0;
        end else if (req1) begin
            w = 1;
        end
        if (LOCK_EN && req0 && req1 && !forced && lock_of(w))
            lock_n = (w == g_cur) ? ((lock_n < LOCK_MAX) ? lock_n + 1 : LOCK_MAX) : 1;
        else
            lock_n = 0;
        if (w >= 0) begin
            last_w  = w;
            c_we    = (w == 0) ? we0    : we1;
            c_addr  = (w == 0) ? addr0  : addr1;
            c_wdata = (w == 0) ? wdata0 : wdata1;
            c_memi  = (w == 0) ? memi0  : memi1;
        end else begin
            c_we = 1'b0;
        end
        g_cur = w;
    endtask

    // Driver tasks.
    task automatic idle_inputs();
        req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0; lock0 = 1'b0; lock1 = 1'b0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0; memi0 = '0; memi1 = '0;
    endtask

    task automatic cycle();
        #1;
        check("stall0", stall0, req0 && (g_cur != 0));
        @(posedge clk);
        model_edge();
        #1;
        check("gnt0", gnt0, g_cur == 0);
        check("gnt1", gnt1, g_cur == 1);
        check("mem_we", mem_we, (g_cur >= 0) && c_we);
        if (g_cur >= 0) begin
            check("mem_addr", mem_addr, c_addr);
            check("mem_memi", mem_memi, c_memi);
            if (c_we) check("mem_wdata", mem_wdata, c_wdata);
        end
        check("rvalid0", rvalid0, exp_rv0);
        check("rvalid1", rvalid1, exp_rv1);
        if (exp_rv0 || exp_rv1) exp_rdata = exp_q.pop_front();
        check("rdata", rdata, exp_rdata);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle_inputs();
        model_reset();
        @(posedge clk);
        #1;
        check("rst_gnt0", gnt0, 1'b0);
        check("rst_gnt1", gnt1, 1'b0);
        check("rst_mem_we", mem_we, 1'b0);
        check("rst_rvalid0", rvalid0, 1'b0);
        check("rst_rvalid1", rvalid1, 1'b0);
        check("rst_rdata", rdata, 32'h0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_mem_wdata", mem_wdata, 32'h0);
        check("rst_mem_memi", mem_memi, 32'h0);
        rst_n = 1'b1;
    endtask

    task automatic drive_random();
        if (!(req0 && g_cur != 0)) begin
            req0   = ($urandom_range(0, 99) < 65);
            we0    = 1'($urandom_range(0, 1));
            addr0  = 32'($urandom_range(0, 63)) << 2;
            wdata0 = $urandom;
            memi0  = 5'($urandom_range(0, 31));
        end
        if (!(req1 && g_cur != 1)) begin
            req1   = ($urandom_range(0, 99) < 65);
            we1    = 1'($urandom_range(0, 1));
            addr1  = 32'($urandom_range(0, 63)) << 2;
            wdata1 = $urandom;
            memi1  = 5'($urandom_range(0, 31));
        end
        lock0 = 1'($urandom_range(0, 1));
        lock1 = 1'($urandom_range(0, 1));
    endtask

    initial begin
        logic [5:0] lock_seq;
        for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);
        do_reset();

        // Single read from port 0.
        req0 = 1'b1; we0 = 1'b0; addr0 = 32'h10; memi0 = 5'h2;
        #1;
        check("t1_stall_c0", stall0, 1'b1);
        cycle();
        check("t1_gnt0", gnt0, 1'b1);
        check("t1_addr", mem_addr, 32'h10);
        req0 = 1'b0;
        #1;
        check("t1_stall_c1", stall0, 1'b0);
        cycle();
        check("t1_rvalid0", rvalid0, 1'b1);
        check("t1_rdata", rdata, 32'hDEADBEEF);

        // Continuous contention alternates grants.
        do_reset();
        req0 = 1'b1; req1 = 1'b1; addr0 = 32'h04; addr1 = 32'h08;
        for (int i = 0; i < 6; i++) begin
            cycle();
            check("t2_gnt0", gnt0, (i % 2) == 0);
            check("t2_stall0", stall0, (i % 2) == 1);
        end

        // Write from port 1 then read it back from port 0.
        idle_inputs();
        cycle();
        req1 = 1'b1; we1 = 1'b1; addr1 = 32'h20; wdata1 = 32'h12345678;
        cycle();
        check("t3_wr_we", mem_we, 1'b1);
        check("t3_wr_gnt1", gnt1, 1'b1);
        req1 = 1'b0; req0 = 1'b1; we0 = 1'b0; addr0 = 32'h20;
        cycle();
        check("t3_rd_we", mem_we, 1'b0);
        req0 = 1'b0;
        cycle();
        check("t3_rvalid0", rvalid0, 1'b1);
        check("t3_rdata", rdata, 32'h12345678);

        // Reset asserted in the middle of a port 1 write cycle.
        idle_inputs();
        req1 = 1'b1; we1 = 1'b1; addr1 = 32'h40; wdata1 = 32'h55AA55AA;
        cycle();
        check("t4_pre_we", mem_we, 1'b1);
        rst_n = 1'b0;
        idle_inputs();
        #1;
        check("t4_we_drop", mem_we, 1'b0);
        check("t4_gnt1_drop", gnt1, 1'b0);
        model_reset();
        @(posedge clk);
        #1;
        check("t4_mem_kept", mem[16], 32'hC0DE0010);
        rst_n = 1'b1;
        req0 = 1'b1; req1 = 1'b1; addr0 = 32'h40; addr1 = 32'h40;
        cycle();
        check("t4_tie_gnt0", gnt0, 1'b1);

        // Port 0 holds lock under contention.
        do_reset();
        lock_seq = LOCK_EN ? 6'b101111 : 6'b010101;
        req0 = 1'b1; req1 = 1'b1; lock0 = 1'b1; addr0 = 32'h0C; addr1 = 32'h18;
        for (int i = 0; i < 6; i++) begin
            cycle();
            check("t5_lock_gnt0", gnt0, lock_seq[i]);
        end

        // Randomized traffic.
        do_reset();
        for (int i = 0; i < 500; i++) begin
            drive_random();
            cycle();
        end
        idle_inputs();
        for (int i = 0; i < 3; i++) cycle();
        check("exp_q_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
